// File: rtl/decoder_seq.sv
// Registered one-hot decoder with a valid/ready request port and a sweep sequencer.
// Optional build macro DECODER_SEQ_RANGE_CHECK_EN rejects requests whose sel is >= OUTS.
module decoder_seq #(
  parameter int SEL_W = 3,
  parameter int OUTS  = 8,
  parameter int DWELL = 1,
  parameter int LEN_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] sel,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic [OUTS-1:0]  y,
  output logic             y_valid,
  output logic             done,
  output logic             err
);

  localparam int              DW_W         = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DWELL_RELOAD = DW_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] LAST_IDX    = SEL_W'(OUTS - 1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic [OUTS-1:0]   y_q, y_d;
  logic              y_valid_q, y_valid_d;
  logic              done_q, done_d;
  logic              req_ok;

  // Out-of-range indices (sel >= OUTS) decode to all-zero.
  function automatic logic [OUTS-1:0] onehot(input logic [SEL_W-1:0] i);
    logic [OUTS-1:0] r;
    r = '0;
    for (int b = 0; b < OUTS; b++) begin
      if (i == SEL_W'(b)) r[b] = 1'b1;
    end
    return r;
  endfunction

  // Wraps at OUTS; an out-of-range start index also steps to 0.
  function automatic logic [SEL_W-1:0] step_idx(input logic [SEL_W-1:0] i);
    return (i >= LAST_IDX) ? '0 : i + SEL_W'(1);
  endfunction

`ifdef DECODER_SEQ_RANGE_CHECK_EN
  logic err_q, err_d;
  assign req_ok = (sel <= LAST_IDX);
`else
  assign req_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      rem_q     <= '0;
      dwell_q   <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef DECODER_SEQ_RANGE_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      dwell_q   <= dwell_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      done_q    <= done_d;
`ifdef DECODER_SEQ_RANGE_CHECK_EN
      err_q     <= err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    dwell_d   = dwell_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid && req_ok) begin
          state_d   = S_ACTIVE;
          idx_d     = sel;
          rem_d     = len;
          dwell_d   = DWELL_RELOAD;
          y_d       = onehot(sel);
          y_valid_d = 1'b1;
        end
      end
      S_ACTIVE: begin
        // Abort takes priority over dwell expiry and completion.
        if (abort) begin
          state_d   = S_IDLE;
          y_d       = '0;
          y_valid_d = 1'b0;
        end else if (dwell_q != '0) begin
          dwell_d = dwell_q - DW_W'(1);
        end else if (rem_q == '0) begin
          state_d   = S_IDLE;
          y_d       = '0;
          y_valid_d = 1'b0;
          done_d    = 1'b1;
        end else begin
          idx_d   = step_idx(idx_q);
          rem_d   = rem_q - LEN_W'(1);
          dwell_d = DWELL_RELOAD;
          y_d     = onehot(step_idx(idx_q));
        end
      end
      default: begin
        state_d   = S_IDLE;
        y_d       = '0;
        y_valid_d = 1'b0;
      end
    endcase
`ifdef DECODER_SEQ_RANGE_CHECK_EN
    err_d = (state_q == S_IDLE) && in_valid && !req_ok;
`endif
  end

  always_comb begin
    in_ready = (state_q == S_IDLE);
    y        = y_q;
    y_valid  = y_valid_q;
    done     = done_q;
`ifdef DECODER_SEQ_RANGE_CHECK_EN
    err      = err_q;
`else
    err      = 1'b0;
`endif
  end

endmodule

// File: tb/tb_decoder_seq.sv
// Bench for decoder_seq: four instances (DWELL 1/2/3, OUTS 8/6) share stimulus and are
// checked every cycle against a queue-based sequence model plus hand-computed literals.
module tb_decoder_seq;

  localparam int N = 4;
`ifdef DECODER_SEQ_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] sel = 3'd0;
  logic [2:0] len = 3'd0;

  logic [7:0] y0, y1, y2;
  logic [5:0] y3;
  logic       v0, v1, v2, v3, d0, d1, d2, d3, e0, e1, e2, e3, r0, r1, r2, r3;

  logic [7:0] dy [N];
  logic       dv [N], dd [N], de [N], dr [N];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decoder_seq #(.SEL_W(3), .OUTS(8), .DWELL(1), .LEN_W(3)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r0), .sel(sel), .len(len),
    .abort(abort), .y(y0), .y_valid(v0), .done(d0), .err(e0));
  decoder_seq #(.SEL_W(3), .OUTS(8), .DWELL(2), .LEN_W(3)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r1), .sel(sel), .len(len),
    .abort(abort), .y(y1), .y_valid(v1), .done(d1), .err(e1));
  decoder_seq #(.SEL_W(3), .OUTS(8), .DWELL(3), .LEN_W(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r2), .sel(sel), .len(len),
    .abort(abort), .y(y2), .y_valid(v2), .done(d2), .err(e2));
  decoder_seq #(.SEL_W(3), .OUTS(6), .DWELL(1), .LEN_W(3)) u_o6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r3), .sel(sel), .len(len),
    .abort(abort), .y(y3), .y_valid(v3), .done(d3), .err(e3));

  assign dy[0] = y0;  assign dy[1] = y1;  assign dy[2] = y2;  assign dy[3] = {2'b00, y3};
  assign dv[0] = v0;  assign dv[1] = v1;  assign dv[2] = v2;  assign dv[3] = v3;
  assign dd[0] = d0;  assign dd[1] = d1;  assign dd[2] = d2;  assign dd[3] = d3;
  assign de[0] = e0;  assign de[1] = e1;  assign de[2] = e2;  assign de[3] = e3;
  assign dr[0] = r0;  assign dr[1] = r1;  assign dr[2] = r2;  assign dr[3] = r3;

  function automatic int dwell_of(input int k);
    return (k == 1) ? 2 : (k == 2) ? 3 : 1;
  endfunction

  function automatic int outs_of(input int k);
    return (k == 3) ? 6 : 8;
  endfunction

  // Index visited at step j of a sweep that starts at s.
  function automatic int idx_at(input int s, input int j, input int o);
    if (s < o) return (s + j) % o;
    return (j == 0) ? s : (j - 1) % o;
  endfunction

  function automatic logic [7:0] oh(input int i, input int o);
    logic [7:0] r;
    r = 8'd0;
    if (i < o) r[i] = 1'b1;
    return r;
  endfunction

  // Model: on accept, the whole expected y stream is queued; each edge consumes one entry.
  logic [7:0] mq [N][64];
  int         mn [N] = '{default: 0};
  int         mp [N] = '{default: 0};
  logic [7:0] ey [N] = '{default: 8'd0};
  logic       ev [N] = '{default: 1'b0};
  logic       ed [N] = '{default: 1'b0};
  logic       ee [N] = '{default: 1'b0};
  logic       er [N] = '{default: 1'b1};

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < N; k++) begin
      ed[k] = 1'b0;
      ee[k] = 1'b0;
      if (!rst_n) begin
        mn[k] = 0;
        mp[k] = 0;
      end else if (mp[k] < mn[k]) begin
        if (abort) begin
          mp[k] = mn[k];
        end else begin
          mp[k] = mp[k] + 1;
          if (mp[k] == mn[k]) ed[k] = 1'b1;
        end
      end else if (in_valid) begin
        if (RC && int'(sel) >= outs_of(k)) begin
          ee[k] = 1'b1;
        end else begin
          mn[k] = 0;
          mp[k] = 0;
          for (int j = 0; j <= int'(len); j++) begin
            for (int d = 0; d < dwell_of(k); d++) begin
              mq[k][mn[k]] = oh(idx_at(int'(sel), j, outs_of(k)), outs_of(k));
              mn[k] = mn[k] + 1;
            end
          end
        end
      end
      ev[k] = (mp[k] < mn[k]);
      ey[k] = ev[k] ? mq[k][mp[k]] : 8'd0;
      er[k] = !ev[k];
    end
  end

  task automatic cmp(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s[%0d] t=%0t got=%h expected=%h", nm, k, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      cmp("y", k, dy[k], ey[k]);
      cmp("y_valid", k, {7'd0, dv[k]}, {7'd0, ev[k]});
      cmp("done", k, {7'd0, dd[k]}, {7'd0, ed[k]});
      cmp("err", k, {7'd0, de[k]}, {7'd0, ee[k]});
      cmp("in_ready", k, {7'd0, dr[k]}, {7'd0, er[k]});
    end
  end

  task automatic lit(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL lit_%s t=%0t got=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [2:0] s, input logic [2:0] l);
    sel = s;
    len = l;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(r0 && r1 && r2 && r3) && n < 200) begin
      tick();
      n++;
    end
    checks = checks + 1;
    if (n >= 200) begin
      failures = failures + 1;
      $display("FAIL wait_idle t=%0t got=busy expected=idle", $time);
    end
    tick();
  endtask

  logic [7:0] sweep2 [8] = '{8'h40, 8'h40, 8'h80, 8'h80, 8'h01, 8'h01, 8'h02, 8'h02};
  logic [7:0] wrap6  [8] = '{8'h10, 8'h20, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) tick();
    lit("rst_y", y0, 8'h00);
    lit("rst_vld", {7'd0, v0}, 8'h00);
    lit("rst_ready", {7'd0, r0}, 8'h01);
    lit("rst_done", {7'd0, d2}, 8'h00);
    rst_n = 1'b1;
    tick();

    // Single decode
    send(3'd5, 3'd0);
    lit("single_y", y0, 8'h20);
    lit("single_vld", {7'd0, v0}, 8'h01);
    lit("single_ready", {7'd0, r0}, 8'h00);
    tick();
    lit("single_end_y", y0, 8'h00);
    lit("single_done", {7'd0, d0}, 8'h01);
    lit("single_ready2", {7'd0, r0}, 8'h01);
    lit("dwell2_hold", y1, 8'h20);
    tick();
    lit("dwell2_done", {7'd0, d1}, 8'h01);
    wait_idle();

    // Sweep with wrap, DWELL=2
    send(3'd6, 3'd3);
    for (int c = 0; c < 8; c++) begin
      lit("sweep_y", y1, sweep2[c]);
      tick();
    end
    lit("sweep_end_y", y1, 8'h00);
    lit("sweep_done", {7'd0, d1}, 8'h01);
    wait_idle();

    // Abort in 5th active cycle, DWELL=3
    send(3'd0, 3'd7);
    repeat (4) tick();
    lit("abort_pre_y", y2, 8'h02);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    lit("abort_y", y2, 8'h00);
    lit("abort_vld", {7'd0, v2}, 8'h00);
    lit("abort_done", {7'd0, d2}, 8'h00);
    lit("abort_ready", {7'd0, r2}, 8'h01);
    wait_idle();

    // Abort coinciding with dwell expiry
    send(3'd0, 3'd7);
    repeat (2) tick();
    lit("abx_pre_y", y2, 8'h01);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    lit("abx_y", y2, 8'h00);
    lit("abx_done", {7'd0, d2}, 8'h00);
    wait_idle();

    // Abort on the would-be completion edge
    send(3'd3, 3'd0);
    lit("abl_pre_y", y0, 8'h08);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    lit("abl_done", {7'd0, d0}, 8'h00);
    tick();
    lit("abl_done2", {7'd0, d0}, 8'h00);
    wait_idle();

    // Abort in IDLE and on the accept edge is ignored
    abort = 1'b1;
    repeat (2) tick();
    send(3'd2, 3'd0);
    abort = 1'b0;
    lit("abacc_y", y0, 8'h04);
    lit("abacc_vld", {7'd0, v0}, 8'h01);
    wait_idle();

    // Back-to-back with in_valid held
    sel = 3'd2;
    len = 3'd1;
    in_valid = 1'b1;
    tick();
    lit("b2b_a0", y0, 8'h04);
    sel = 3'd4;
    len = 3'd0;
    tick();
    lit("b2b_a1", y0, 8'h08);
    tick();
    lit("b2b_gap_y", y0, 8'h00);
    lit("b2b_gap_done", {7'd0, d0}, 8'h01);
    lit("b2b_gap_ready", {7'd0, r0}, 8'h01);
    tick();
    in_valid = 1'b0;
    lit("b2b_b0", y0, 8'h10);
    lit("b2b_b0_vld", {7'd0, v0}, 8'h01);
    wait_idle();

    // Range: sel=7 on OUTS=6 and OUTS=8
    send(3'd7, 3'd0);
    lit("rng_o8_y", y0, 8'h80);
    lit("rng_o6_y", {2'b00, y3}, 8'h00);
    if (RC) begin
      lit("rng_o6_err", {7'd0, e3}, 8'h01);
      lit("rng_o6_vld", {7'd0, v3}, 8'h00);
      lit("rng_o6_ready", {7'd0, r3}, 8'h01);
    end else begin
      lit("rng_o6_vld", {7'd0, v3}, 8'h01);
      lit("rng_o6_err", {7'd0, e3}, 8'h00);
    end
    tick();
    lit("rng_o6_err_end", {7'd0, e3}, 8'h00);
    lit("rng_o6_y_end", {2'b00, y3}, 8'h00);
    wait_idle();

    send(3'd7, 3'd2);
    tick();
    lit("rng_step_y", {2'b00, y3}, RC ? 8'h00 : 8'h01);
    wait_idle();

    // len beyond OUTS-1 repeats indices
    send(3'd4, 3'd7);
    for (int c = 0; c < 8; c++) begin
      lit("wrap6_y", {2'b00, y3}, wrap6[c]);
      tick();
    end
    lit("wrap6_done", {7'd0, d3}, 8'h01);
    wait_idle();

    // Asynchronous reset mid-sweep
    send(3'd1, 3'd7);
    repeat (2) tick();
    #1 rst_n = 1'b0;
    #1;
    lit("arst_y1", y0, 8'h00);
    lit("arst_y2", y1, 8'h00);
    lit("arst_vld", {7'd0, v2}, 8'h00);
    lit("arst_done", {7'd0, d0}, 8'h00);
    lit("arst_ready", {7'd0, r1}, 8'h01);
    #2 rst_n = 1'b1;
    tick();
    send(3'd3, 3'd0);
    lit("post_rst_y", y0, 8'h08);
    tick();
    lit("post_rst_done", {7'd0, d0}, 8'h01);
    wait_idle();

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
